// File: rtl/als_pkg.sv
// Shared defaults, slew FSM state type and clamp helper for the ALS backlight path.
package als_pkg;

   localparam int ALS_DATA_W   = 12;
   localparam int ALS_AVG_LOG2 = 3;
   localparam int ALS_DUTY_W   = 8;
   localparam int ALS_DUTY_MIN = 16;
   localparam int ALS_DUTY_MAX = 255;
   localparam int ALS_HYST     = 4;
   localparam int ALS_STEP_DIV = 1000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COUNT,
      S_STEP
   } slew_state_t;

   // Saturate v into [lo, hi].
   function automatic int clamp(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/als_moving_avg.sv
// 2^AVG_LOG2-sample moving average over the ALS readings. Running sum is
// DATA_W+AVG_LOG2 bits wide, so it cannot overflow. Average and full flag
// are registered one cycle after the accepted sample.
module als_moving_avg
   import als_pkg::*;
#(
   parameter int DATA_W   = ALS_DATA_W,
   parameter int AVG_LOG2 = ALS_AVG_LOG2
) (
   input  logic              I_clk,
   input  logic              I_rst,
   input  logic [DATA_W-1:0] I_data,
   input  logic              I_valid,
   output logic [DATA_W-1:0] O_avg,
   output logic              O_avg_valid,
   output logic              O_full
);

   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SUM_W = DATA_W + AVG_LOG2;
   localparam logic [AVG_LOG2:0]   FILL_MAX = DEPTH[AVG_LOG2:0];
   localparam logic [AVG_LOG2:0]   FILL_ONE = {{AVG_LOG2{1'b0}}, 1'b1};
   localparam logic [AVG_LOG2-1:0] WP_ONE   = {{(AVG_LOG2-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0]   win [DEPTH];
   logic [AVG_LOG2-1:0] wp;
   logic [AVG_LOG2:0]   fill;
   logic [SUM_W-1:0]    sum;
   // vld_pipe[0]: sum holds a fresh sample; vld_pipe[1]: O_avg just updated
   logic [1:0]          vld_pipe;

   // Window buffer, running sum, write pointer and saturating fill count
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         for (int i = 0; i < DEPTH; i++) win[i] <= '0;
         wp   <= '0;
         fill <= '0;
         sum  <= '0;
      end else if (I_valid) begin
         sum     <= sum + SUM_W'(I_data) - SUM_W'(win[wp]);
         win[wp] <= I_data;
         wp      <= wp + WP_ONE;
         if (fill != FILL_MAX) fill <= fill + FILL_ONE;
      end
   end

   // Register the average and the full flag that belongs to the same sample
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         vld_pipe <= '0;
         O_avg    <= '0;
         O_full   <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[0], I_valid};
         if (vld_pipe[0]) begin
            O_avg  <= sum[SUM_W-1 -: DATA_W];
            O_full <= (fill == FILL_MAX);
         end
      end
   end

   assign O_avg_valid = vld_pipe[1];

endmodule

// File: rtl/als_backlight_ctrl.sv
// ALS-driven backlight duty controller: averaged reading -> clamped target
// with hysteresis (or manual target) -> duty slewed one LSB per STEP_DIV clocks.
module als_backlight_ctrl
   import als_pkg::*;
#(
   parameter int DATA_W   = ALS_DATA_W,
   parameter int AVG_LOG2 = ALS_AVG_LOG2,
   parameter int DUTY_W   = ALS_DUTY_W,
   parameter int DUTY_MIN = ALS_DUTY_MIN,
   parameter int DUTY_MAX = ALS_DUTY_MAX,
   parameter int HYST     = ALS_HYST,
   parameter int STEP_DIV = ALS_STEP_DIV
) (
   input  logic              I_clk,
   input  logic              I_rst,
   input  logic [DATA_W-1:0] I_bright_data,
   input  logic              I_bright_valid,
   input  logic              I_manual_en,
   input  logic [DUTY_W-1:0] I_manual_duty,
   output logic [DATA_W-1:0] O_avg,
   output logic              O_avg_valid,
   output logic [DUTY_W-1:0] O_duty,
   output logic [DUTY_W-1:0] O_target,
   output logic              O_busy
);

   // Counter only ever holds values up to STEP_DIV-2
   localparam int TICK_W = (STEP_DIV > 2) ? $clog2(STEP_DIV - 1) : 1;
   localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(STEP_DIV - 2);
   localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
   localparam logic [TICK_W-1:0] TICK_ZERO = '0;
   localparam logic [DUTY_W-1:0] DUTY_RST  = DUTY_W'(DUTY_MIN);
   localparam logic [DUTY_W-1:0] DUTY_ONE  = DUTY_W'(1);

   logic              avg_full;
   logic [DUTY_W-1:0] raw;
   logic [DUTY_W-1:0] cand;
   logic [DUTY_W-1:0] man_duty;
   int                diff;
   logic              hyst_ok;

   slew_state_t       state, state_n;
   logic [TICK_W-1:0] tick, tick_n;
   logic [DUTY_W-1:0] duty_n;

   als_moving_avg #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2)
   ) u_avg (
      .I_clk       (I_clk),
      .I_rst       (I_rst),
      .I_data      (I_bright_data),
      .I_valid     (I_bright_valid),
      .O_avg       (O_avg),
      .O_avg_valid (O_avg_valid),
      .O_full      (avg_full)
   );

   assign raw = O_avg[DATA_W-1 -: DUTY_W];

   // Candidate targets and hysteresis test against the current target
   always_comb begin
      cand     = DUTY_W'(clamp(int'(raw), DUTY_MIN, DUTY_MAX));
      man_duty = DUTY_W'(clamp(int'(I_manual_duty), DUTY_MIN, DUTY_MAX));
      diff     = int'(cand) - int'(O_target);
      hyst_ok  = (diff >= HYST) || (diff <= -HYST);
   end

   // Target register: manual follows every cycle, auto only on a full-window average
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         O_target <= DUTY_RST;
      end else if (I_manual_en) begin
         O_target <= man_duty;
      end else if (O_avg_valid && avg_full && hyst_ok) begin
         O_target <= cand;
      end
   end

   // Slew FSM state, tick counter and duty registers
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state  <= S_IDLE;
         tick   <= '0;
         O_duty <= DUTY_RST;
      end else begin
         state  <= state_n;
         tick   <= tick_n;
         O_duty <= duty_n;
      end
   end

   // Slew FSM next state; direction is chosen fresh at every step so a
   // mid-ramp target change reverses without overshoot
   always_comb begin
      state_n = state;
      tick_n  = tick;
      duty_n  = O_duty;
      case (state)
         S_IDLE: begin
            if (O_duty != O_target) begin
               tick_n  = TICK_LOAD;
               state_n = S_COUNT;
            end
         end
         S_COUNT: begin
            if (O_duty == O_target)  state_n = S_IDLE;
            else if (tick == TICK_ZERO) state_n = S_STEP;
            else                     tick_n  = tick - TICK_ONE;
         end
         S_STEP: begin
            if (O_duty < O_target)      duty_n = O_duty + DUTY_ONE;
            else if (O_duty > O_target) duty_n = O_duty - DUTY_ONE;
            if (duty_n == O_target) begin
               state_n = S_IDLE;
            end else begin
               tick_n  = TICK_LOAD;
               state_n = S_COUNT;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign O_busy = (O_duty != O_target);

endmodule

// File: tb/tb_als_backlight_ctrl.sv
// Scoreboarded bench for als_backlight_ctrl with a short step period.
module tb_als_backlight_ctrl;

   localparam int DATA_W   = 12;
   localparam int DUTY_W   = 8;
   localparam int STEP_DIV = 4;

   logic              I_clk = 1'b0;
   logic              I_rst = 1'b1;
   logic [DATA_W-1:0] I_bright_data = '0;
   logic              I_bright_valid = 1'b0;
   logic              I_manual_en = 1'b0;
   logic [DUTY_W-1:0] I_manual_duty = '0;
   logic [DATA_W-1:0] O_avg;
   logic              O_avg_valid;
   logic [DUTY_W-1:0] O_duty;
   logic [DUTY_W-1:0] O_target;
   logic              O_busy;

   int n_vec = 0;
   int n_err = 0;

   // bench-side averaging model and expected-average queue
   int m_win [8];
   int m_wp  = 0;
   int m_sum = 0;
   int exp_q [$];

   als_backlight_ctrl #(.STEP_DIV(STEP_DIV)) dut (
      .I_clk          (I_clk),
      .I_rst          (I_rst),
      .I_bright_data  (I_bright_data),
      .I_bright_valid (I_bright_valid),
      .I_manual_en    (I_manual_en),
      .I_manual_duty  (I_manual_duty),
      .O_avg          (O_avg),
      .O_avg_valid    (O_avg_valid),
      .O_duty         (O_duty),
      .O_target       (O_target),
      .O_busy         (O_busy)
   );

   always #5 I_clk = ~I_clk;

   // scoreboard: every average pulse must match the oldest expected value
   always @(negedge I_clk) begin
      if (!I_rst && O_avg_valid) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL avg_unexpected: got pulse with avg %0h, expected none", O_avg);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (O_avg !== DATA_W'(e)) begin
               n_err++;
               $display("FAIL avg_value: got %0h expected %0h", O_avg, e);
            end
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_win[i] = 0;
      m_wp = 0;
      m_sum = 0;
      exp_q.delete();
   endtask

   // drive one sample for one cycle; consecutive calls are back-to-back
   task automatic send(input int d);
      I_bright_data  = DATA_W'(d);
      I_bright_valid = 1'b1;
      m_sum = m_sum + d - m_win[m_wp];
      m_win[m_wp] = d;
      m_wp = (m_wp + 1) % 8;
      exp_q.push_back(m_sum >> 3);
      @(posedge I_clk); #1;
      I_bright_valid = 1'b0;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge I_clk); #1;
      end
   endtask

   // measure a ramp until O_busy drops; reports, does not judge
   task automatic wait_idle(input int budget, output int steps, output int bad,
                            output int first_d, output int mn, output int mx,
                            output bit tmo);
      int last, prev, d;
      steps = 0; bad = 0; first_d = 0; tmo = 1'b1; last = -1;
      prev = int'(O_duty); mn = prev; mx = prev;
      for (int cyc = 0; cyc < budget; cyc++) begin
         @(posedge I_clk); #1;
         if (int'(O_duty) != prev) begin
            d = int'(O_duty) - prev;
            if (steps == 0) first_d = d;
            steps++;
            if (d != 1 && d != -1) bad++;
            if (last >= 0 && cyc - last != STEP_DIV) bad++;
            last = cyc;
            prev = int'(O_duty);
            if (prev < mn) mn = prev;
            if (prev > mx) mx = prev;
         end
         if (!O_busy) begin
            tmo = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      n_vec++;
      if (O_duty !== 8'd16 || O_target !== 8'd16 || O_avg !== 12'h0 || O_busy !== 1'b0 || O_avg_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: got duty %0d target %0d avg %0h busy %0b vld %0b, expected 16 16 0 0 0",
                  O_duty, O_target, O_avg, O_busy, O_avg_valid);
      end
   endtask

   task automatic test_warmup_ramp();
      int steps, bad, fd, mn, mx;
      bit tmo;
      for (int i = 0; i < 7; i++) send(12'h800);
      cycles(3);
      n_vec++;
      if (O_target !== 8'd16) begin
         n_err++; $display("FAIL warmup_hold: got target %0d expected 16", O_target);
      end
      send(12'h800);
      cycles(1);
      n_vec++;
      if (O_target !== 8'd16) begin
         n_err++; $display("FAIL target_latency_early: got target %0d expected 16", O_target);
      end
      cycles(1);
      n_vec++;
      if (O_target !== 8'd128) begin
         n_err++; $display("FAIL target_after_fill: got target %0d expected 128", O_target);
      end
      wait_idle(1000, steps, bad, fd, mn, mx, tmo);
      n_vec++;
      if (tmo || steps != 112 || bad != 0 || O_duty !== 8'd128 || O_busy !== 1'b0) begin
         n_err++;
         $display("FAIL ramp_up: got tmo %0b steps %0d bad %0d duty %0d busy %0b, expected 0 112 0 128 0",
                  tmo, steps, bad, O_duty, O_busy);
      end
   endtask

   task automatic test_hysteresis();
      int steps, bad, fd, mn, mx;
      bit tmo;
      for (int i = 0; i < 8; i++) send(12'h830);
      cycles(3);
      n_vec++;
      if (O_target !== 8'd128) begin
         n_err++; $display("FAIL hyst_hold: got target %0d expected 128", O_target);
      end
      for (int i = 0; i < 8; i++) send(12'h840);
      cycles(2);
      n_vec++;
      if (O_target !== 8'd132) begin
         n_err++; $display("FAIL hyst_move: got target %0d expected 132", O_target);
      end
      wait_idle(200, steps, bad, fd, mn, mx, tmo);
      n_vec++;
      if (tmo || steps != 4 || bad != 0 || O_duty !== 8'd132) begin
         n_err++;
         $display("FAIL hyst_ramp: got tmo %0b steps %0d bad %0d duty %0d, expected 0 4 0 132", tmo, steps, bad, O_duty);
      end
   endtask

   task automatic test_clamp_wrap();
      for (int i = 0; i < 8; i++) send(12'h000);
      cycles(2);
      n_vec++;
      if (O_target !== 8'd16) begin
         n_err++; $display("FAIL clamp_low: got target %0d expected 16", O_target);
      end
      for (int i = 0; i < 4; i++) send(12'hFFF);
      cycles(1);
      n_vec++;
      if (O_avg !== 12'h7FF) begin
         n_err++; $display("FAIL half_window: got avg %0h expected 7ff", O_avg);
      end
      for (int i = 0; i < 4; i++) send(12'hFFF);
      cycles(2);
      n_vec++;
      if (O_avg !== 12'hFFF || O_target !== 8'd255) begin
         n_err++; $display("FAIL clamp_high: got avg %0h target %0d expected fff 255", O_avg, O_target);
      end
   endtask

   task automatic test_reversal();
      int steps, bad, fd, mn, mx;
      bit tmo;
      I_manual_en = 1'b1;
      I_manual_duty = 8'd100;
      cycles(1);
      n_vec++;
      if (O_target !== 8'd100) begin
         n_err++; $display("FAIL manual_target: got target %0d expected 100", O_target);
      end
      wait_idle(3000, steps, bad, fd, mn, mx, tmo);
      n_vec++;
      if (tmo || bad != 0 || O_duty !== 8'd100) begin
         n_err++; $display("FAIL manual_settle: got tmo %0b bad %0d duty %0d, expected 0 0 100", tmo, bad, O_duty);
      end
      I_manual_duty = 8'd200;
      cycles(14);
      n_vec++;
      if (!(O_duty > 8'd100 && O_duty < 8'd200) || O_busy !== 1'b1) begin
         n_err++; $display("FAIL ramp_toward_200: got duty %0d busy %0b, expected 101..199 1", O_duty, O_busy);
      end
      I_manual_duty = 8'd50;
      wait_idle(2000, steps, bad, fd, mn, mx, tmo);
      n_vec++;
      if (tmo || bad != 0 || fd != -1 || mn != 50 || O_duty !== 8'd50) begin
         n_err++;
         $display("FAIL reversal: got tmo %0b bad %0d first %0d min %0d duty %0d, expected 0 0 -1 50 50",
                  tmo, bad, fd, mn, O_duty);
      end
      // back to auto: the full 0xFFF window must not move the target by itself
      I_manual_en = 1'b0;
      cycles(5);
      n_vec++;
      if (O_target !== 8'd50) begin
         n_err++; $display("FAIL auto_return_hold: got target %0d expected 50", O_target);
      end
   endtask

   task automatic test_reset_midramp();
      I_manual_en = 1'b1;
      I_manual_duty = 8'd5;
      cycles(1);
      n_vec++;
      if (O_target !== 8'd16) begin
         n_err++; $display("FAIL manual_clamp: got target %0d expected 16", O_target);
      end
      I_manual_duty = 8'd200;
      cycles(10);
      @(negedge I_clk); #2;
      I_rst = 1'b1;
      I_manual_en = 1'b0;
      #1;
      n_vec++;
      if (O_duty !== 8'd16 || O_target !== 8'd16 || O_avg !== 12'h0 || O_busy !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: got duty %0d target %0d avg %0h busy %0b, expected 16 16 0 0",
                  O_duty, O_target, O_avg, O_busy);
      end
      model_reset();
      @(posedge I_clk); #1;
      I_rst = 1'b0;
      for (int i = 0; i < 7; i++) send(12'hFFF);
      cycles(4);
      n_vec++;
      if (O_target !== 8'd16 || O_duty !== 8'd16) begin
         n_err++; $display("FAIL rewarm_hold: got target %0d duty %0d expected 16 16", O_target, O_duty);
      end
      send(12'hFFF);
      cycles(2);
      n_vec++;
      if (O_target !== 8'd255) begin
         n_err++; $display("FAIL rewarm_move: got target %0d expected 255", O_target);
      end
   endtask

   initial begin
      model_reset();
      cycles(3);
      I_rst = 1'b0;
      cycles(1);
      test_reset();
      test_warmup_ramp();
      test_hysteresis();
      test_clamp_wrap();
      test_reversal();
      test_reset_midramp();
      cycles(3);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL avg_missing: got %0d pending averages expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
